// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types for the debug controller
package dbg_pkg;

  localparam int BP_CNT_W = 6;

  typedef enum logic [3:0] {
    FN_NONE      = 4'd0,
    FN_PAUSE     = 4'd1,
    FN_RESUME    = 4'd2,
    FN_STEP      = 4'd3,
    FN_RESET     = 4'd4,
    FN_STATUS    = 4'd5,
    FN_BR_PT_ADD = 4'd6,
    FN_BR_PT_RM  = 4'd7,
    FN_MEM_RD    = 4'd8,
    FN_MEM_WR    = 4'd9,
    FN_REG_RD    = 4'd10,
    FN_REG_WR    = 4'd11
  } debug_fn_t;

  typedef enum logic [2:0] {
    OP_PAUSE  = 3'd0,
    OP_RESUME = 3'd1,
    OP_RESET  = 3'd2,
    OP_MEM_RD = 3'd3,
    OP_MEM_WR = 3'd4,
    OP_REG_RD = 3'd5,
    OP_REG_WR = 3'd6
  } mcu_op_t;

  typedef enum logic [2:0] {
    ST_OK          = 3'd0,
    ST_BP_HIT      = 3'd1,
    ST_ERR_STATE   = 3'd2,
    ST_ERR_BP_FULL = 3'd3,
    ST_ERR_BP_NONE = 3'd4,
    ST_ERR_MCU     = 3'd5,
    ST_ERR_TIMEOUT = 3'd6,
    ST_ERR_CMD     = 3'd7
  } dbg_status_t;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_WAIT       = 3'd2,
    S_STEP_PAUSE = 3'd3,
    S_RESP       = 3'd4
  } dbg_state_t;

endpackage

// File: rtl/dbg_bp_table.sv
// rtl/dbg_bp_table.sv - breakpoint storage with pc match, lookup, lowest-free add and remove
module dbg_bp_table
  import dbg_pkg::*;
#(
  parameter int NUM_BP = 8,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [ADDR_W-1:0]   lookup_addr,
  input  logic                add_en,
  input  logic                rm_en,
  output logic                pc_match,
  output logic                found,
  output logic                full,
  output logic [BP_CNT_W-1:0] count
);

  logic [NUM_BP-1:0] valid_q;
  logic [ADDR_W-1:0] addr_q [NUM_BP];
  logic [NUM_BP-1:0] pc_hits;
  logic [NUM_BP-1:0] addr_hits;
  logic [NUM_BP-1:0] free_oh;

  always_comb begin
    pc_hits   = '0;
    addr_hits = '0;
    count     = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      pc_hits[i]   = valid_q[i] && (addr_q[i] == pc);
      addr_hits[i] = valid_q[i] && (addr_q[i] == lookup_addr);
      count        = count + BP_CNT_W'(valid_q[i]);
    end
  end

  // Lowest clear bit of the valid vector, as a one-hot; zero when full.
  assign free_oh  = ~valid_q & (valid_q + NUM_BP'(1));
  assign pc_match = |pc_hits;
  assign found    = |addr_hits;
  assign full     = &valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (add_en && !found && free_oh[i]) begin
          valid_q[i] <= 1'b1;
          addr_q[i]  <= lookup_addr;
        end else if (rm_en && addr_hits[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dbg_ctrl.sv
// rtl/dbg_ctrl.sv - debug command controller driving the MCU request/busy handshake
module dbg_ctrl
  import dbg_pkg::*;
#(
  parameter int NUM_BP  = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_fn,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mcu_busy,
  input  logic [DATA_W-1:0] mcu_rd_data,
  input  logic              mcu_error,
  output logic              mcu_req,
  output logic [2:0]        mcu_op,
  output logic [ADDR_W-1:0] mcu_addr,
  output logic [DATA_W-1:0] mcu_wdata,
  output logic              paused
);

  localparam int TW = $clog2(TIMEOUT + 1);

  dbg_state_t        state_q, state_n;
  logic              mcu_req_q, mcu_req_n;
  mcu_op_t           op_q, op_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              rsp_valid_q, rsp_valid_n;
  dbg_status_t       status_q, status_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic              paused_q, paused_n;
  logic              step_q, step_n;
  logic              hit_q, hit_n;
  logic [ADDR_W-1:0] hit_pc_q, hit_pc_n;
  logic [TW-1:0]     tmo_cnt_q;

  logic                bp_add, bp_rm;
  logic                bp_pc_match, bp_found, bp_full;
  logic [BP_CNT_W-1:0] bp_count;
  logic                bp_hit, tmo_hit;

  debug_fn_t         fn;
  logic              mcu_go;
  mcu_op_t           go_op;
  dbg_status_t       loc_status;
  logic [DATA_W-1:0] loc_data;

  dbg_bp_table #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) u_bp_table (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .lookup_addr (cmd_addr),
    .add_en      (bp_add),
    .rm_en       (bp_rm),
    .pc_match    (bp_pc_match),
    .found       (bp_found),
    .full        (bp_full),
    .count       (bp_count)
  );

  assign bp_hit    = bp_pc_match && !paused_q;
  assign cmd_ready = (state_q == S_IDLE) && !bp_hit;
  assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_n     = state_q;
    mcu_req_n   = mcu_req_q;
    op_n        = op_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    rsp_valid_n = rsp_valid_q;
    status_n    = status_q;
    data_n      = data_q;
    paused_n    = paused_q;
    step_n      = step_q;
    hit_n       = hit_q;
    hit_pc_n    = hit_pc_q;
    bp_add      = 1'b0;
    bp_rm       = 1'b0;
    fn          = debug_fn_t'(cmd_fn);
    mcu_go      = 1'b0;
    go_op       = OP_PAUSE;
    loc_status  = ST_OK;
    loc_data    = '0;

    case (state_q)
      S_IDLE: begin
        if (bp_hit) begin
          state_n   = S_REQ;
          mcu_req_n = 1'b1;
          op_n      = OP_PAUSE;
          hit_n     = 1'b1;
          step_n    = 1'b0;
          hit_pc_n  = pc;
        end else if (cmd_valid) begin
          hit_n  = 1'b0;
          step_n = 1'b0;
          case (fn)
            FN_PAUSE:  if (!paused_q) begin mcu_go = 1'b1; go_op = OP_PAUSE; end
            FN_RESUME: if (paused_q) begin mcu_go = 1'b1; go_op = OP_RESUME; end
            FN_STEP: begin
              if (paused_q) begin
                mcu_go = 1'b1;
                go_op  = OP_RESUME;
                step_n = 1'b1;
              end else begin
                loc_status = ST_ERR_STATE;
              end
            end
            FN_RESET: begin mcu_go = 1'b1; go_op = OP_RESET; end
            FN_STATUS: begin
              loc_data[0]    = paused_q;
              loc_data[1]    = mcu_busy;
              loc_data[13:8] = bp_count;
            end
            FN_BR_PT_ADD: begin
              bp_add = 1'b1;
              if (!bp_found && bp_full) loc_status = ST_ERR_BP_FULL;
            end
            FN_BR_PT_RM: begin
              bp_rm = 1'b1;
              if (!bp_found) loc_status = ST_ERR_BP_NONE;
            end
            FN_MEM_RD: begin mcu_go = paused_q; go_op = OP_MEM_RD; end
            FN_MEM_WR: begin mcu_go = paused_q; go_op = OP_MEM_WR; end
            FN_REG_RD: begin mcu_go = paused_q; go_op = OP_REG_RD; end
            FN_REG_WR: begin mcu_go = paused_q; go_op = OP_REG_WR; end
            default:   loc_status = ST_ERR_CMD;
          endcase
          // Memory/register access while running is refused without touching the MCU.
          if ((fn == FN_MEM_RD || fn == FN_MEM_WR || fn == FN_REG_RD || fn == FN_REG_WR)
              && !paused_q)
            loc_status = ST_ERR_STATE;
          if (mcu_go) begin
            state_n   = S_REQ;
            mcu_req_n = 1'b1;
            op_n      = go_op;
            addr_n    = cmd_addr;
            wdata_n   = cmd_data;
          end else begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            status_n    = loc_status;
            data_n      = loc_data;
          end
        end
      end

      S_REQ, S_STEP_PAUSE: begin
        if (mcu_busy) begin
          state_n   = S_WAIT;
          mcu_req_n = 1'b0;
        end else if (tmo_hit) begin
          state_n     = S_RESP;
          mcu_req_n   = 1'b0;
          rsp_valid_n = 1'b1;
          status_n    = ST_ERR_TIMEOUT;
          data_n      = '0;
          step_n      = 1'b0;
        end
      end

      S_WAIT: begin
        if (!mcu_busy) begin
          if (step_q && !mcu_error) begin
            // Resume half of a step is done; immediately request the pause.
            state_n   = S_STEP_PAUSE;
            mcu_req_n = 1'b1;
            op_n      = OP_PAUSE;
            step_n    = 1'b0;
            paused_n  = 1'b0;
          end else begin
            state_n     = S_RESP;
            rsp_valid_n = 1'b1;
            step_n      = 1'b0;
            status_n    = mcu_error ? ST_ERR_MCU : (hit_q ? ST_BP_HIT : ST_OK);
            data_n      = '0;
            if (op_q == OP_MEM_RD || op_q == OP_REG_RD) data_n = mcu_rd_data;
            else if (hit_q)                             data_n = DATA_W'(hit_pc_q);
            if (!mcu_error) begin
              if (op_q == OP_PAUSE)                          paused_n = 1'b1;
              else if (op_q == OP_RESUME || op_q == OP_RESET) paused_n = 1'b0;
            end
          end
        end else if (tmo_hit) begin
          state_n     = S_RESP;
          rsp_valid_n = 1'b1;
          status_n    = ST_ERR_TIMEOUT;
          data_n      = '0;
          step_n      = 1'b0;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcu_req_q   <= 1'b0;
      op_q        <= OP_PAUSE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      status_q    <= ST_OK;
      data_q      <= '0;
      paused_q    <= 1'b0;
      step_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_pc_q    <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_n;
      mcu_req_q   <= mcu_req_n;
      op_q        <= op_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      rsp_valid_q <= rsp_valid_n;
      status_q    <= status_n;
      data_q      <= data_n;
      paused_q    <= paused_n;
      step_q      <= step_n;
      hit_q       <= hit_n;
      hit_pc_q    <= hit_pc_n;
      if (state_n != state_q)
        tmo_cnt_q <= '0;
      else if (state_q == S_REQ || state_q == S_WAIT || state_q == S_STEP_PAUSE)
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end

  assign mcu_req    = mcu_req_q;
  assign mcu_op     = op_q;
  assign mcu_addr   = addr_q;
  assign mcu_wdata  = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_data   = data_q;
  assign paused     = paused_q;

endmodule

// File: doc/dbg_ctrl.md
# dbg_ctrl

Parametrised debug controller between the serial command decoder and the MCU. It accepts decoded debug commands over a valid/ready handshake and drives a request/busy handshake to the MCU for pause, resume, step, reset, memory and register access. It maintains a breakpoint table supporting add and remove. Every command produces exactly one response, and breakpoint hits produce unsolicited responses.

## Interface
Parameters:
- NUM_BP, 8: breakpoint slots, 1..32
- ADDR_W, 32: address / pc width
- DATA_W, 32: data width, ≥16
- TIMEOUT, 1024: max cycles per MCU handshake phase

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_fn  in  4  debug_fn_t
- cmd_addr  in  ADDR_W  memory/register address or breakpoint address
- cmd_data  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_status  out  3  dbg_status_t
- rsp_data  out  DATA_W  read data / status word / hit pc
- pc  in  ADDR_W  MCU program counter
- mcu_busy  in  1  MCU acknowledging / executing request
- mcu_rd_data  in  DATA_W  MCU read result
- mcu_error  in  1  sampled at completion
- mcu_req  out  1  request strobe
- mcu_op  out  3  mcu_op_t
- mcu_addr  out  ADDR_W
- mcu_wdata  out  DATA_W
- paused  out  1  MCU known halted

## Operation
- States: IDLE, REQ, WAIT, STEP_PAUSE, RESP.
- cmd_ready = (state==IDLE) && !hit. A hit takes priority over a same-cycle command.
- Local commands go straight to RESP; rsp_data=0 unless stated:
  - STATUS: rsp_data[0]=paused, [1]=mcu_busy, [13:8]=valid bp count, else 0.
  - BR_PT_ADD: duplicate address → OK, no new entry; table full → ERR_BP_FULL; otherwise write lowest free slot.
  - BR_PT_RM: clear matching entry; no match → ERR_BP_NONE.
  - PAUSE while paused, or RESUME while running → OK.
  - STEP, MEM_*, REG_* while running → ERR_STATE.
  - NONE or undefined cmd_fn → ERR_CMD.
- MCU commands: latch op/addr/data, enter REQ.
  - REQ: mcu_req=1 until mcu_busy seen high, then WAIT with mcu_req=0.
  - WAIT: on mcu_busy low, capture mcu_rd_data and mcu_error.
  - Status ERR_MCU if error, else OK. rsp_data=read data for reads, else 0.
  - PAUSE completion sets paused. RESUME and RESET completion clear paused.
- STEP: RESUME handshake, then STEP_PAUSE issues PAUSE handshake. Response after the pause completes; paused=1. Breakpoints are ignored during a step.
- Timeout: a per-phase counter resets on each state entry. Reaching TIMEOUT in REQ or WAIT gives ERR_TIMEOUT. The controller drops mcu_req, goes to RESP, and leaves paused unchanged.
- Breakpoint hit: in IDLE with !paused and pc equal to any valid entry. Controller issues a PAUSE handshake, then responds BP_HIT with rsp_data=pc captured at the hit (zero-extended).
- RESP: hold rsp_* stable while rsp_valid && !rsp_ready. Return to IDLE the cycle after the handshake.
- Breakpoints survive MCU RESET; only the reset port clears them.

## Timing
- Reset:
  - State → IDLE; bp table invalidated.
  - Outputs zero: rsp_valid, mcu_req, paused, rsp_*, mcu_*.
  - cmd_ready=1 the first cycle after reset deasserts.
  - Reset mid-operation abandons the MCU handshake with no response.
- Local command accepted at cycle N → rsp_valid at N+1; IDLE at N+2 given rsp_ready=1 at N+1.
- MCU command accepted at N → mcu_req=1 at N+1. If busy=1 at N+k, mcu_req=0 at N+k+1. Busy low at cycle M → rsp_valid at M+1.
- Hit detected at N → mcu_req (PAUSE) at N+1.
- mcu_op, mcu_addr and mcu_wdata are stable from mcu_req rise until WAIT exits.
- All outputs registered except cmd_ready.

## Structure
- Package dbg_pkg holds:
  - debug_fn_t: NONE, PAUSE, RESUME, STEP, RESET, STATUS, BR_PT_ADD, BR_PT_RM, MEM_RD, MEM_WR, REG_RD, REG_WR.
  - mcu_op_t: PAUSE, RESUME, RESET, MEM_RD, MEM_WR, REG_RD, REG_WR.
  - dbg_status_t: OK, BP_HIT, ERR_STATE, ERR_BP_FULL, ERR_BP_NONE, ERR_MCU, ERR_TIMEOUT, ERR_CMD.
- Sub-module dbg_bp_table, parametrised by NUM_BP/ADDR_W:
  - Holds valid+addr storage, the pc match, and the add/remove lookup.
  - Lowest-free-slot priority encoder and population count.
  - Single-cycle add/remove.

## Test plan
- PAUSE with MCU busy pulsing 3 cycles → mcu_req 1 cycle after accept; OK 1 cycle after busy falls; paused=1. Repeat PAUSE → immediate OK.
- Add 0x100, 0x104, then add 0x100 again → OK ×3 and STATUS count=2. Fill NUM_BP=8 → 9th add ERR_BP_FULL. Remove 0x200 → ERR_BP_NONE.
- Running with bp 0x40, pc reaches 0x40 with cmd_valid the same cycle → cmd_ready=0. PAUSE issued; BP_HIT with rsp_data=0x40, then the pending command accepted.
- Paused, MEM_RD addr 0x8, MCU returns 0xDEADBEEF → OK, rsp_data=0xDEADBEEF. mcu_error=1 on REG_WR → ERR_MCU.
- STEP while paused → RESUME then PAUSE handshakes; single OK; paused=1. STEP while running → ERR_STATE.
- MCU never raises busy → ERR_TIMEOUT after TIMEOUT cycles. Reset asserted mid-WAIT → all outputs zero next cycle; bp count=0.
